mem_access_unit: RTL
====================

# mem_access_unit

- Multi-cycle load/store unit between the execute stage's ALU result and write-back. It replaces the zero-latency external data-memory model with a valid/ready bus master.
- Performs byte-lane steering, sign/zero extension and misalignment detection.
- Stalls the core until the access completes.

## Interface
- XLEN, 32: address/data width; byte-lane logic is defined for 32 only.
- TIMEOUT_CYCLES, 16: watchdog limit in REQ; used only with the Configuration macro.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  1  load request from control unit (MEM_Read).
- req_write  in  1  store request from control unit (Mem_Write).
- addr  in  XLEN  byte address from the ALU.
- wdata  in  XLEN  store data (rs2).
- data_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are treated as W.
- stall  out  1  freezes PC and register write while high.
- rdata  out  XLEN  extended load data to write-back; valid in DONE.
- fault  out  1  one-cycle pulse on misaligned access or timeout.
- bus_valid  out  1  bus request.
- bus_ready  in  1  bus accepts/completes the request.
- bus_we  out  1  1 = write.
- bus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_rdata  in  XLEN  read word; sampled when bus_valid && bus_ready.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - Aligned request (req_read or req_write) → REQ. Bus fields are registered at this edge.
  - Misaligned request → fault pulses, stall stays 0, no bus activity, stays in IDLE.
- **REQ**
  - bus_valid=1.
  - bus_ready=1 → DONE; for reads, rdata is registered at this edge.
  - Otherwise stay in REQ.
- **DONE**
  - stall=0; the core commits at the end of this cycle.
  - Unconditionally → IDLE, so a request that is still asserted is not re-issued.
- stall = (IDLE && aligned request) || REQ.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00; B is always aligned.
- req_read and req_write both high → treated as a write.
- Store steering:
  - B: be = 4'b0001 << addr[1:0], wdata[7:0] replicated ×4.
  - H: be = addr[1] ? 1100 : 0011, wdata[15:0] replicated ×2.
  - W: be = 1111, wdata unchanged.
- Load steering:
  - Select the byte at addr[1:0] or the halfword at addr[1] from bus_rdata.
  - B/H sign-extend; BU/HU zero-extend.
  - bus_be on loads = same mask as for stores (informational).
- rdata holds its value until the next completed load. Stores leave rdata unchanged.

## Timing
- **Reset (asynchronous):**
  - state=IDLE.
  - stall, fault, bus_valid and bus_we all 0.
  - bus_addr, bus_be, bus_wdata and rdata all 0.
  - Takes effect mid-transaction immediately; no bus_ready is awaited.
- **Latency:**
  - Request seen in cycle 0, REQ in cycle 1, DONE in cycle 1+N, where N = cycles until bus_ready (minimum 1).
  - stall is high for 1+N cycles.
- **Handshake:**
  - Once bus_valid rises, bus_valid/we/addr/be/wdata stay stable until the cycle bus_ready is sampled high.
  - bus_valid drops in DONE.
  - bus_ready while bus_valid=0 is ignored.
- **Core contract:** req_*, addr, wdata and data_type are held stable while stall=1.
- fault is combinational in IDLE for a misaligned request, or a registered one-cycle pulse in DONE on timeout.

## Configuration
- Macro: MEM_ACCESS_TIMEOUT_EN.
- **Defined:**
  - A counter increments each cycle in REQ.
  - When it reaches TIMEOUT_CYCLES without bus_ready, bus_valid drops and the FSM → DONE.
  - fault pulses in DONE; a timed-out load writes rdata=0.
  - The counter clears on leaving REQ.
- **Undefined:**
  - No counter; REQ waits indefinitely.
  - fault is driven only by misalignment.

## Test plan
- LW addr=0x100, bus_ready=1 on first REQ cycle, bus_rdata=0x87654321 → bus_be=1111, bus_addr=0x100, stall high 2 cycles, rdata=0x87654321 in DONE.
- LB addr=0x103, bus_rdata=0x80FF_FF12 → rdata=0xFFFFFF80; LBU, same stimulus → rdata=0x00000080.
- SH addr=0x102, wdata=0x0000BEEF, bus_ready delayed 3 cycles → bus_we=1, bus_be=1100, bus_addr=0x100, bus_wdata=0xBEEFBEEF, all stable 4 REQ cycles, stall high 5 cycles.
- LW addr=0x101 → fault=1 for one cycle, bus_valid never rises, stall=0, rdata unchanged.
- reset asserted in the 2nd REQ cycle of a pending SW → bus_valid and stall low immediately; after release, a new LW completes normally.
- MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, LW with bus_ready held 0 → bus_valid high exactly 16 cycles, fault pulse in DONE, rdata=0, FSM back in IDLE.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store unit sitting between the ALU result
// and write-back. Issues one valid/ready bus transaction per aligned request,
// steers byte lanes for stores, extracts and extends load data, and flags
// misaligned accesses. The core is stalled until the access completes.
//
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to add a REQ-state watchdog
// that abandons a transaction after TIMEOUT_CYCLES cycles without bus_ready,
// pulses fault and returns rdata=0 for a timed-out load.
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      data_type,
    output logic            stall,
    output logic [XLEN-1:0] rdata,
    output logic            fault,
    output logic            bus_valid,
    input  logic            bus_ready,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic            bus_valid_reg;
    logic            bus_we_reg;
    logic [XLEN-1:0] bus_addr_reg;
    logic [3:0]      bus_be_reg;
    logic [XLEN-1:0] bus_wdata_reg;
    logic [XLEN-1:0] rdata_reg;

    // Load-extraction context captured at issue so extraction does not depend
    // on the core keeping addr/data_type stable through the DONE edge.
    logic [1:0]      lane_reg;
    logic            is_byte_reg;
    logic            is_half_reg;
    logic            is_unsigned_reg;

    // Request decode. funct3[1:0]=00 is byte, 01 is halfword, anything else
    // (including the undefined codes) is handled as a full word.
    logic            req_any;
    logic            is_byte;
    logic            is_half;
    logic            misaligned;
    logic            issue;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;

    assign req_any    = req_read | req_write;
    assign is_byte    = (data_type[1:0] == 2'b00);
    assign is_half    = (data_type[1:0] == 2'b01);
    assign misaligned = is_half ? addr[0] : (is_byte ? 1'b0 : (addr[1:0] != 2'b00));
    assign issue      = (state_reg == IDLE) && req_any && !misaligned;

    // Byte-enable mask, shared by loads and stores.
    always_comb begin
        be_next = 4'b1111;
        if (is_byte) begin
            be_next = 4'b0001 << addr[1:0];
        end else if (is_half) begin
            be_next = addr[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Store data lane replication: each lane picks the source byte that would
    // land on it for the access size.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wlane
            assign wdata_next[8*gi +: 8] = is_byte ? wdata[7:0] :
                                           is_half ? wdata[8*(gi%2) +: 8] :
                                                     wdata[8*gi +: 8];
        end
    endgenerate

    // Load extraction from the returned word.
    logic [7:0]      rd_byte [4];
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;
    logic [XLEN-1:0] load_ext;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_rlane
            assign rd_byte[gi] = bus_rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_byte[lane_reg];
    assign sel_half = lane_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    // Sign- or zero-extend the selected lane according to the captured type.
    always_comb begin
        load_ext = bus_rdata;
        if (is_byte_reg) begin
            load_ext = {{(XLEN-8){!is_unsigned_reg && sel_byte[7]}}, sel_byte};
        end else if (is_half_reg) begin
            load_ext = {{(XLEN-16){!is_unsigned_reg && sel_half[15]}}, sel_half};
        end
    end

    logic timeout_fault;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt_reg;
    logic             timeout_fault_reg;

    assign timeout_fault = timeout_fault_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYCLES[0];
    assign timeout_fault      = 1'b0;
`endif

    // Transaction FSM with registered bus fields and load result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            bus_valid_reg     <= 1'b0;
            bus_we_reg        <= 1'b0;
            bus_addr_reg      <= '0;
            bus_be_reg        <= '0;
            bus_wdata_reg     <= '0;
            rdata_reg         <= '0;
            lane_reg          <= '0;
            is_byte_reg       <= 1'b0;
            is_half_reg       <= 1'b0;
            is_unsigned_reg   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            timeout_cnt_reg   <= '0;
            timeout_fault_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        state_reg       <= REQ;
                        bus_valid_reg   <= 1'b1;
                        bus_we_reg      <= req_write;
                        bus_addr_reg    <= {addr[XLEN-1:2], 2'b00};
                        bus_be_reg      <= be_next;
                        bus_wdata_reg   <= wdata_next;
                        lane_reg        <= addr[1:0];
                        is_byte_reg     <= is_byte;
                        is_half_reg     <= is_half;
                        is_unsigned_reg <= data_type[2];
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        state_reg     <= DONE;
                        bus_valid_reg <= 1'b0;
                        if (!bus_we_reg) begin
                            rdata_reg <= load_ext;
                        end
`ifdef MEM_ACCESS_TIMEOUT_EN
                        timeout_cnt_reg <= '0;
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        state_reg         <= DONE;
                        bus_valid_reg     <= 1'b0;
                        timeout_fault_reg <= 1'b1;
                        timeout_cnt_reg   <= '0;
                        if (!bus_we_reg) begin
                            rdata_reg <= '0;
                        end
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    // DONE: always return to IDLE so a held request is not re-issued.
                    state_reg <= IDLE;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    timeout_fault_reg <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Stall and the misalignment fault are combinational from the live request;
    // both are forced low while reset is asserted.
    assign stall = !reset && (issue || (state_reg == REQ));
    assign fault = !reset && ((state_reg == IDLE && req_any && misaligned) || timeout_fault);

    assign bus_valid = bus_valid_reg;
    assign bus_we    = bus_we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_wdata = bus_wdata_reg;
    assign rdata     = rdata_reg;

endmodule
